// File: rtl/rally_if.sv
// Handshake bundle between the collision logic, the rally sequencer and the score display.
interface rally_if;
  logic        start;
  logic        pl1_col;
  logic        pl2_col;
  logic        gnd_col;
  logic [11:0] ball_posx;
  logic        ball_hold;
  logic        serve_side;
  logic        ovr_touch;
  logic [4:0]  score_pl1;
  logic [4:0]  score_pl2;
  logic        point_pl1;
  logic        point_pl2;
  logic        game_over;
  logic        winner;

  modport master (
    output start, pl1_col, pl2_col, gnd_col, ball_posx,
    input  ball_hold, serve_side, ovr_touch, score_pl1, score_pl2,
           point_pl1, point_pl2, game_over, winner
  );

  modport slave (
    input  start, pl1_col, pl2_col, gnd_col, ball_posx,
    output ball_hold, serve_side, ovr_touch, score_pl1, score_pl2,
           point_pl1, point_pl2, game_over, winner
  );
endinterface

// File: rtl/rally_ctrl.sv
// Match-level sequencer: serve hold, touch counting with ghost window, point award,
// scorekeeping and win detection.
module rally_ctrl #(
  parameter int NET_X        = 512,
  parameter int BALL_HALF    = 32,
  parameter int MAX_TOUCH    = 3,
  parameter int WIN_SCORE    = 15,
  parameter int HOLD_CYCLES  = 65_000_000,
  parameter int GHOST_CYCLES = 16_250_000
) (
  input logic   clk,
  input logic   rst,
  rally_if.slave bus
);

  localparam int GHOST_W = $clog2(GHOST_CYCLES + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int CNT_W   = $clog2(MAX_TOUCH + 2);

  typedef enum logic [2:0] {IDLE, SERVE, RALLY, POINT, GAME_OVER} state_t;

  state_t             state, state_nxt;
  logic               pl1_col_p1, pl2_col_p1, gnd_col_p1;
  logic [GHOST_W-1:0] ghost_cnt, ghost_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic [CNT_W-1:0]   touch_cnt, touch_nxt;
  logic               last_toucher, last_nxt;
  logic [4:0]         score1, score1_nxt, score2, score2_nxt;
  logic               serve_r, serve_nxt;
  logic               ovr_r, ovr_nxt;
  logic               pt1_r, pt1_nxt, pt2_r, pt2_nxt;
  logic               match_end, match_end_nxt;
  logic               winner_r, winner_nxt;
  logic               pl1_evt, pl2_evt, gnd_evt, touch_evt, toucher;
  logic               award, award_p2, left_side;
  logic [12:0]        ball_ctr;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  function automatic logic match_done(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] aw, bw;
    aw = {1'b0, a};
    bw = {1'b0, b};
    return (a == 5'd31) || (b == 5'd31) ||
           ((aw >= 6'(WIN_SCORE)) && (aw >= bw + 6'd2)) ||
           ((bw >= 6'(WIN_SCORE)) && (bw >= aw + 6'd2));
  endfunction

  // Stage p0 -> p1: rising-edge detection against the previous sample
  assign pl1_evt   = bus.pl1_col & ~pl1_col_p1;
  assign pl2_evt   = bus.pl2_col & ~pl2_col_p1;
  assign gnd_evt   = bus.gnd_col & ~gnd_col_p1;
  assign touch_evt = (pl1_evt | pl2_evt) && (ghost_cnt == '0);
  assign toucher   = ~pl1_evt;   // player 1 wins a simultaneous touch
  assign ball_ctr  = {1'b0, bus.ball_posx} + 13'(BALL_HALF);
  assign left_side = ball_ctr < 13'(NET_X);

  always_comb begin
    state_nxt     = state;
    ghost_nxt     = (ghost_cnt != '0) ? ghost_cnt - GHOST_W'(1) : ghost_cnt;
    hold_nxt      = hold_cnt;
    touch_nxt     = touch_cnt;
    last_nxt      = last_toucher;
    score1_nxt    = score1;
    score2_nxt    = score2;
    serve_nxt     = serve_r;
    ovr_nxt       = ovr_r;
    pt1_nxt       = 1'b0;
    pt2_nxt       = 1'b0;
    match_end_nxt = match_end;
    winner_nxt    = winner_r;
    award         = 1'b0;
    award_p2      = 1'b0;

    case (state)
      IDLE, GAME_OVER: begin
        if (bus.start) begin
          state_nxt     = SERVE;
          score1_nxt    = '0;
          score2_nxt    = '0;
          serve_nxt     = 1'b0;
          match_end_nxt = 1'b0;
          winner_nxt    = 1'b0;
          ovr_nxt       = 1'b0;
          touch_nxt     = '0;
          last_nxt      = 1'b0;
        end
      end
      SERVE: begin
        if (touch_evt) begin
          state_nxt = RALLY;
          touch_nxt = CNT_W'(1);
          last_nxt  = toucher;
          ghost_nxt = GHOST_W'(GHOST_CYCLES);
        end
      end
      RALLY: begin
        if (gnd_evt) begin
          award    = 1'b1;
          award_p2 = left_side;
        end else if (touch_evt) begin
          ghost_nxt = GHOST_W'(GHOST_CYCLES);
          if (toucher != last_toucher) begin
            touch_nxt = CNT_W'(1);
            last_nxt  = toucher;
          end else if (touch_cnt == CNT_W'(MAX_TOUCH)) begin
            award    = 1'b1;
            award_p2 = ~toucher;
            ovr_nxt  = 1'b1;
          end else begin
            touch_nxt = touch_cnt + CNT_W'(1);
          end
        end
      end
      POINT: begin
        if (hold_cnt <= HOLD_W'(1)) begin
          ovr_nxt = 1'b0;
          if (match_end) begin
            state_nxt  = GAME_OVER;
            winner_nxt = score2 > score1;
          end else begin
            state_nxt = SERVE;
            touch_nxt = '0;
            last_nxt  = 1'b0;
          end
        end else begin
          hold_nxt = hold_cnt - HOLD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Rally scoring: the point winner also takes the serve
    if (award) begin
      state_nxt = POINT;
      hold_nxt  = HOLD_W'(HOLD_CYCLES);
      if (award_p2) begin
        score2_nxt = sat_inc(score2);
        pt2_nxt    = 1'b1;
        serve_nxt  = 1'b1;
      end else begin
        score1_nxt = sat_inc(score1);
        pt1_nxt    = 1'b1;
        serve_nxt  = 1'b0;
      end
      match_end_nxt = match_done(score1_nxt, score2_nxt);
    end
  end

  // Stage p1: architectural state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      pl1_col_p1   <= 1'b0;
      pl2_col_p1   <= 1'b0;
      gnd_col_p1   <= 1'b0;
      ghost_cnt    <= '0;
      hold_cnt     <= '0;
      touch_cnt    <= '0;
      last_toucher <= 1'b0;
      score1       <= '0;
      score2       <= '0;
      serve_r      <= 1'b0;
      ovr_r        <= 1'b0;
      pt1_r        <= 1'b0;
      pt2_r        <= 1'b0;
      match_end    <= 1'b0;
      winner_r     <= 1'b0;
    end else begin
      state        <= state_nxt;
      pl1_col_p1   <= bus.pl1_col;
      pl2_col_p1   <= bus.pl2_col;
      gnd_col_p1   <= bus.gnd_col;
      ghost_cnt    <= ghost_nxt;
      hold_cnt     <= hold_nxt;
      touch_cnt    <= touch_nxt;
      last_toucher <= last_nxt;
      score1       <= score1_nxt;
      score2       <= score2_nxt;
      serve_r      <= serve_nxt;
      ovr_r        <= ovr_nxt;
      pt1_r        <= pt1_nxt;
      pt2_r        <= pt2_nxt;
      match_end    <= match_end_nxt;
      winner_r     <= winner_nxt;
    end
  end

  assign bus.ball_hold  = (state == IDLE) || (state == SERVE) || (state == GAME_OVER);
  assign bus.game_over  = (state == GAME_OVER);
  assign bus.serve_side = serve_r;
  assign bus.ovr_touch  = ovr_r;
  assign bus.score_pl1  = score1;
  assign bus.score_pl2  = score2;
  assign bus.point_pl1  = pt1_r;
  assign bus.point_pl2  = pt2_r;
  assign bus.winner     = winner_r;

endmodule

// File: tb/tb_rally_ctrl.sv
// Bench for rally_ctrl: directed match scenarios plus random play against a rule-level model.
module tb_rally_ctrl;

  localparam int NET_X     = 512;
  localparam int BALL_HALF = 32;
  localparam int MAX_TOUCH = 3;
  localparam int WIN_SCORE = 3;
  localparam int HOLD      = 10;
  localparam int GHOST     = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_SERVE = 1;
  localparam int PH_RALLY = 2;
  localparam int PH_POINT = 3;
  localparam int PH_DONE  = 4;

  logic clk;
  logic rst;
  rally_if bus();

  rally_ctrl #(
    .NET_X(NET_X), .BALL_HALF(BALL_HALF), .MAX_TOUCH(MAX_TOUCH),
    .WIN_SCORE(WIN_SCORE), .HOLD_CYCLES(HOLD), .GHOST_CYCLES(GHOST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  int ph = PH_IDLE;
  int m_ghost = 0, m_hold = 0, m_cnt = 0, m_last_who = 0;
  int m_s1 = 0, m_s2 = 0;
  bit m_side = 0, m_ovr = 0, m_pt1 = 0, m_pt2 = 0, m_match = 0, m_win = 0;
  bit mp1 = 0, mp2 = 0, mg = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit match_won(input int a, input int b);
    return (a >= WIN_SCORE && a - b >= 2) || (b >= WIN_SCORE && b - a >= 2) ||
           a == 31 || b == 31;
  endfunction

  task automatic model_award(input int who);
    if (who == 1) begin
      m_s1 = (m_s1 < 31) ? m_s1 + 1 : 31;
      m_pt1 = 1; m_side = 0;
    end else begin
      m_s2 = (m_s2 < 31) ? m_s2 + 1 : 31;
      m_pt2 = 1; m_side = 1;
    end
    m_match = match_won(m_s1, m_s2);
    ph = PH_POINT;
    m_hold = HOLD;
  endtask

  task automatic model_step(input bit r, input bit s, input bit p1, input bit p2,
                            input bit g, input int px);
    bit e1, e2, eg, ready;
    int who;
    if (!r) begin
      ph = PH_IDLE; m_ghost = 0; m_hold = 0; m_cnt = 0; m_last_who = 0;
      m_s1 = 0; m_s2 = 0; m_side = 0; m_ovr = 0; m_pt1 = 0; m_pt2 = 0;
      m_match = 0; m_win = 0; mp1 = 0; mp2 = 0; mg = 0;
    end else begin
      e1 = p1 && !mp1;
      e2 = p2 && !mp2;
      eg = g && !mg;
      mp1 = p1; mp2 = p2; mg = g;
      ready = (m_ghost == 0) && (e1 || e2);
      who = e1 ? 1 : 2;
      if (m_ghost > 0) m_ghost--;
      m_pt1 = 0; m_pt2 = 0;
      case (ph)
        PH_IDLE, PH_DONE: if (s) begin
          ph = PH_SERVE; m_s1 = 0; m_s2 = 0; m_side = 0; m_match = 0;
          m_win = 0; m_ovr = 0; m_cnt = 0; m_last_who = 0;
        end
        PH_SERVE: if (ready) begin
          ph = PH_RALLY; m_cnt = 1; m_last_who = who; m_ghost = GHOST;
        end
        PH_RALLY: begin
          if (eg) model_award((px + BALL_HALF < NET_X) ? 2 : 1);
          else if (ready) begin
            m_ghost = GHOST;
            if (who != m_last_who) begin
              m_cnt = 1; m_last_who = who;
            end else if (m_cnt + 1 > MAX_TOUCH) begin
              model_award(3 - who);
              m_ovr = 1;
            end else m_cnt++;
          end
        end
        PH_POINT: begin
          m_hold--;
          if (m_hold == 0) begin
            m_ovr = 0;
            if (m_match) begin
              ph = PH_DONE; m_win = (m_s2 > m_s1);
            end else begin
              ph = PH_SERVE; m_cnt = 0; m_last_who = 0;
            end
          end
        end
        default: ph = PH_IDLE;
      endcase
    end
  endtask

  task automatic compare_all();
    bit exp_hold;
    exp_hold = (ph == PH_IDLE) || (ph == PH_SERVE) || (ph == PH_DONE);
    check_val("m_ball_hold",  32'(bus.ball_hold),  32'(exp_hold));
    check_val("m_serve_side", 32'(bus.serve_side), 32'(m_side));
    check_val("m_ovr_touch",  32'(bus.ovr_touch),  32'(m_ovr));
    check_val("m_score_pl1",  32'(bus.score_pl1),  m_s1);
    check_val("m_score_pl2",  32'(bus.score_pl2),  m_s2);
    check_val("m_point_pl1",  32'(bus.point_pl1),  32'(m_pt1));
    check_val("m_point_pl2",  32'(bus.point_pl2),  32'(m_pt2));
    check_val("m_game_over",  32'(bus.game_over),  32'(ph == PH_DONE));
    check_val("m_winner",     32'(bus.winner),     32'(m_win));
  endtask

  task automatic cyc(input bit r, input bit s, input bit p1, input bit p2,
                     input bit g, input int px);
    @(negedge clk);
    rst = r;
    bus.start = s;
    bus.pl1_col = p1;
    bus.pl2_col = p2;
    bus.gnd_col = g;
    bus.ball_posx = 12'(px);
    @(posedge clk);
    #1;
    model_step(r, s, p1, p2, g, px);
    compare_all();
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
  endtask

  // rise on the given players, then hold low so the next rise lands gap cycles later
  task automatic touch_gap(input bit p1, input bit p2, input int gap);
    cyc(1, 0, p1, p2, 0, 0);
    quiet(gap - 1);
  endtask

  task automatic play_point(input int who);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, (who == 1) ? 700 : 400);
    quiet(HOLD);
  endtask

  initial begin
    bit lp1, lp2, lg, r, s;
    rst = 1'b0;
    bus.start = 1'b0; bus.pl1_col = 1'b0; bus.pl2_col = 1'b0;
    bus.gnd_col = 1'b0; bus.ball_posx = '0;

    // reset and start
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check_val("rst_hold", 32'(bus.ball_hold), 1);
    check_val("rst_score1", 32'(bus.score_pl1), 0);
    check_val("rst_score2", 32'(bus.score_pl2), 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check_val("serve_hold", 32'(bus.ball_hold), 1);
    check_val("serve_side0", 32'(bus.serve_side), 0);
    cyc(1, 0, 1, 0, 0, 0);
    check_val("serve_release", 32'(bus.ball_hold), 0);

    // ground point on player 1's half
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 400);
    check_val("gnd_point_pl2", 32'(bus.point_pl2), 1);
    check_val("gnd_score2", 32'(bus.score_pl2), 1);
    check_val("gnd_side", 32'(bus.serve_side), 1);
    for (int i = 0; i < HOLD; i++) begin
      cyc(1, 0, 0, 0, 0, 400);
      check_val("hold_len", 32'(bus.ball_hold), (i == HOLD - 1) ? 1 : 0);
    end

    // over-touch with an ignored touch inside the ghost window
    touch_gap(1, 0, 6);
    touch_gap(1, 0, 2);
    touch_gap(1, 0, 4);
    touch_gap(1, 0, 6);
    check_val("no_fault_yet", 32'(bus.ovr_touch), 0);
    cyc(1, 0, 1, 0, 0, 0);
    check_val("fault_ovr", 32'(bus.ovr_touch), 1);
    check_val("fault_point2", 32'(bus.point_pl2), 1);
    check_val("fault_score2", 32'(bus.score_pl2), 2);
    quiet(HOLD);
    check_val("ovr_cleared", 32'(bus.ovr_touch), 0);

    // alternating touches never fault
    for (int i = 0; i < 8; i++) begin
      touch_gap(1, 0, 6);
      touch_gap(0, 1, 6);
    end
    check_val("alt_no_fault", 32'(bus.ovr_touch), 0);
    check_val("alt_score1", 32'(bus.score_pl1), 0);
    check_val("alt_score2", 32'(bus.score_pl2), 2);

    // ground beats touch in the same cycle
    cyc(1, 0, 1, 0, 1, 700);
    check_val("simul_point1", 32'(bus.point_pl1), 1);
    check_val("simul_score1", 32'(bus.score_pl1), 1);
    quiet(HOLD);

    // joint serve touch goes to player 1: three more pl1 touches fault
    touch_gap(1, 1, 6);
    touch_gap(1, 0, 6);
    touch_gap(1, 0, 6);
    cyc(1, 0, 1, 0, 0, 0);
    check_val("joint_serve_pl1", 32'(bus.ovr_touch), 1);
    check_val("joint_score2", 32'(bus.score_pl2), 3);
    quiet(HOLD);
    check_val("over_3_1", 32'(bus.game_over), 1);
    check_val("winner_pl2", 32'(bus.winner), 1);

    // restart, then 3-2 is not enough, 4-2 ends the match
    cyc(1, 1, 0, 0, 0, 0);
    check_val("restart_score1", 32'(bus.score_pl1), 0);
    check_val("restart_over", 32'(bus.game_over), 0);
    play_point(1); play_point(2); play_point(1); play_point(2); play_point(1);
    check_val("at_3_2_over", 32'(bus.game_over), 0);
    check_val("at_3_2_s1", 32'(bus.score_pl1), 3);
    check_val("at_3_2_s2", 32'(bus.score_pl2), 2);
    play_point(1);
    check_val("at_4_2_over", 32'(bus.game_over), 1);
    check_val("at_4_2_winner", 32'(bus.winner), 0);
    cyc(1, 1, 0, 0, 0, 0);
    check_val("restart2_hold", 32'(bus.ball_hold), 1);
    check_val("restart2_score1", 32'(bus.score_pl1), 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    check_val("start_ignored_rally", 32'(bus.ball_hold), 0);
    cyc(0, 0, 0, 0, 0, 0);
    check_val("abort_hold", 32'(bus.ball_hold), 1);
    check_val("abort_over", 32'(bus.game_over), 0);
    cyc(1, 0, 0, 0, 0, 0);

    // random play against the model
    lp1 = 0; lp2 = 0; lg = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) lp1 = ~lp1;
      if ($urandom_range(0, 3) == 0) lp2 = ~lp2;
      if ($urandom_range(0, 29) == 0) lg = ~lg;
      s = ($urandom_range(0, 49) == 0);
      r = ($urandom_range(0, 499) != 0);
      cyc(r, s, lp1, lp2, lg, int'($urandom_range(300, 800)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
